if_fetch_queue: RTL and testbench

//  Instruction-fetch front end that sits directly upstream of decode, under control of the hazard/stall unit.
//  - Owns the PC and drives the instruction-memory address.
//  - Absorbs instruction-memory wait states (iready_n).
//  - Buffers fetched {PC, instruction} pairs in a small FIFO so decode stalls never drop or re-fetch an instruction.
//  - Redirects on a taken branch.

---
 rtl/if_fetch_queue_pkg.sv | 26 ++
 rtl/if_fetch_queue_if.sv | 42 ++++
 rtl/if_fetch_queue_inst_skid_fifo.sv | 64 ++++++
 rtl/if_fetch_queue.sv | 82 ++++++++
 tb/tb_if_fetch_queue.sv | 158 +++++++++++++++
 5 files changed

// File: rtl/if_fetch_queue_pkg.sv
// Fetch front-end shared definitions.
// Fetch entry layout and PC helpers.
package if_fetch_queue_pkg;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
  localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;
  localparam int ENTRY_W = 64;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;

  function automatic logic [31:0] align_pc(
    input logic [31:0] a
  );
    return a & ~32'h3;
  endfunction

  function automatic logic [31:0] next_pc(
    input logic [31:0] a
  );
    return a + 32'd4;
  endfunction

endpackage

// File: rtl/if_fetch_queue_if.sv
// Fetch-queue bus: memory side, redirect,
// stall and decode-facing outputs.
interface if_fetch_queue_if;

  logic [31:0] iad;
  logic [31:0] idata;
  logic        iready_n;
  logic        branch_PC_contral;
  logic [31:0] branch_PC;
  logic        stall_ID;
  logic [31:0] Instraction_pype;
  logic [31:0] PC_pype;
  logic        inst_valid_pype;
  logic [1:0]  fifo_count;

  modport master (
    output iad,
    input  idata,
    input  iready_n,
    input  branch_PC_contral,
    input  branch_PC,
    input  stall_ID,
    output Instraction_pype,
    output PC_pype,
    output inst_valid_pype,
    output fifo_count
  );

  modport slave (
    input  iad,
    output idata,
    output iready_n,
    output branch_PC_contral,
    output branch_PC,
    output stall_ID,
    input  Instraction_pype,
    input  PC_pype,
    input  inst_valid_pype,
    input  fifo_count
  );

endinterface

// File: rtl/if_fetch_queue_inst_skid_fifo.sv
// Small synchronous FIFO with flush and
// a combinational head read.
module inst_skid_fifo #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 64,
  localparam int PW = $clog2(DEPTH),
  localparam int CW = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic             flush,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             empty,
  output logic             full,
  output logic [CW-1:0]    count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic do_push;
  logic do_pop;

  assign empty = (count == '0);
  assign full = (count == CW'(DEPTH));
  assign do_pop = pop && !empty;
  // A full queue still accepts when the head leaves this cycle.
  assign do_push = push && (!full || do_pop);
  assign dout = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push && !flush) begin
      mem[wr_ptr] <= din;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + PW'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
      unique case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/if_fetch_queue.sv
// Fetch front end: PC register, wait-state
// absorption, decode skid queue, redirect.
module if_fetch_queue
  import if_fetch_queue_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter logic [31:0] RESET_PC = RESET_PC_DEF
) (
  input logic clk,
  input logic rst,
  if_fetch_queue_if.master bus
);

  localparam int CW = $clog2(DEPTH) + 1;

  logic [31:0] pc;
  logic fetch_ok;
  logic pop;
  logic redirect;
  logic empty;
  logic full;
  logic [CW-1:0] cnt;
  logic [ENTRY_W-1:0] din;
  logic [ENTRY_W-1:0] dout;
  fetch_entry_t wr_e;
  fetch_entry_t hd_e;

  assign redirect = bus.branch_PC_contral;
  assign pop = !empty && !bus.stall_ID && !redirect;
  assign fetch_ok = !bus.iready_n && (!full || pop) && !redirect;

  always_comb begin
    wr_e = '0;
    wr_e.pc = pc;
    wr_e.instr = bus.idata;
  end

  assign din = wr_e;
  assign hd_e = fetch_entry_t'(dout);

  always_ff @(posedge clk) begin
    if (!rst) begin
      pc <= RESET_PC;
    end else if (redirect) begin
      pc <= align_pc(bus.branch_PC);
    end else if (fetch_ok) begin
      pc <= next_pc(pc);
    end
  end

  inst_skid_fifo #(
    .DEPTH(DEPTH),
    .WIDTH(ENTRY_W)
  ) u_fifo (
    .clk(clk),
    .rst(rst),
    .push(fetch_ok),
    .pop(pop),
    .flush(redirect),
    .din(din),
    .dout(dout),
    .empty(empty),
    .full(full),
    .count(cnt)
  );

  // Empty queue presents a NOP so decode never sees stale storage.
  always_comb begin
    bus.Instraction_pype = NOP_INSTR;
    bus.PC_pype = '0;
    bus.inst_valid_pype = 1'b0;
    if (!empty) begin
      bus.Instraction_pype = hd_e.instr;
      bus.PC_pype = hd_e.pc;
      bus.inst_valid_pype = 1'b1;
    end
  end

  assign bus.iad = pc;
  assign bus.fifo_count = 2'(cnt);

endmodule

// File: tb/tb_if_fetch_queue.sv
// Directed bench for the fetch queue:
// reset, wait states, stall, full, branch, wrap.
module tb_if_fetch_queue;

  logic clk;
  logic rst;
  int errors;
  int checks;

  if_fetch_queue_if bus();

  if_fetch_queue #(
    .DEPTH(2),
    .RESET_PC(32'h0000_0000)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(
    input string tag,
    input logic [31:0] obs,
    input logic [31:0] exp
  );
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h",
             tag, obs, exp);
    end
  endtask

  task automatic chk_out(
    input string tag,
    input logic [31:0] iad,
    input logic [31:0] ins,
    input logic [31:0] pcp,
    input logic vld,
    input logic [1:0] cnt
  );
    chk({tag, ".iad"}, bus.iad, iad);
    chk({tag, ".instr"}, bus.Instraction_pype, ins);
    chk({tag, ".pc"}, bus.PC_pype, pcp);
    chk({tag, ".valid"}, 32'(bus.inst_valid_pype), 32'(vld));
    chk({tag, ".count"}, 32'(bus.fifo_count), 32'(cnt));
  endtask

  initial begin
    errors = 0;
    checks = 0;
    rst = 1'b0;
    bus.iready_n = 1'b0;
    bus.idata = 32'h0050_0093;
    bus.branch_PC_contral = 1'b0;
    bus.branch_PC = 32'h0;
    bus.stall_ID = 1'b0;

    // 1. reset
    tick();
    tick();
    chk_out("rst", 32'h0, 32'h13, 32'h0, 1'b0, 2'd0);
    rst = 1'b1;
    tick();
    chk_out("first", 32'h4, 32'h0050_0093, 32'h0, 1'b1, 2'd1);
    bus.idata = 32'h0000_0113;
    tick();
    chk_out("second", 32'h8, 32'h113, 32'h4, 1'b1, 2'd1);

    // 2. wait states at PC=8
    bus.iready_n = 1'b1;
    bus.idata = 32'hDEAD_BEEF;
    tick();
    chk_out("ws1", 32'h8, 32'h13, 32'h0, 1'b0, 2'd0);
    tick();
    tick();
    chk_out("ws3", 32'h8, 32'h13, 32'h0, 1'b0, 2'd0);
    bus.iready_n = 1'b0;
    bus.idata = 32'h0000_0213;
    tick();
    chk_out("resume", 32'hC, 32'h213, 32'h8, 1'b1, 2'd1);
    bus.idata = 32'h0000_0313;
    tick();
    chk_out("fetchC", 32'h10, 32'h313, 32'hC, 1'b1, 2'd1);
    bus.iready_n = 1'b1;
    tick();
    chk_out("drain", 32'h10, 32'h13, 32'h0, 1'b0, 2'd0);

    // 3. decode stall fills the queue
    bus.iready_n = 1'b0;
    bus.stall_ID = 1'b1;
    bus.idata = 32'h0000_0413;
    tick();
    chk_out("st1", 32'h14, 32'h413, 32'h10, 1'b1, 2'd1);
    bus.idata = 32'h0000_0513;
    tick();
    chk_out("st2", 32'h18, 32'h413, 32'h10, 1'b1, 2'd2);
    bus.idata = 32'h0000_0613;
    tick();
    chk_out("full", 32'h18, 32'h413, 32'h10, 1'b1, 2'd2);

    // 4. release: pop+push on full queue
    bus.stall_ID = 1'b0;
    tick();
    chk_out("rel1", 32'h1C, 32'h513, 32'h14, 1'b1, 2'd2);
    bus.idata = 32'h0000_0713;
    tick();
    chk_out("rel2", 32'h20, 32'h613, 32'h18, 1'b1, 2'd2);
    bus.idata = 32'h0000_0813;
    tick();
    chk_out("rel3", 32'h24, 32'h713, 32'h1C, 1'b1, 2'd2);

    // 5. branch while stalled and full
    bus.stall_ID = 1'b1;
    bus.branch_PC_contral = 1'b1;
    bus.branch_PC = 32'h0000_0103;
    bus.idata = 32'hDEAD_BEEF;
    tick();
    chk_out("br", 32'h100, 32'h13, 32'h0, 1'b0, 2'd0);
    bus.branch_PC_contral = 1'b0;
    bus.stall_ID = 1'b0;
    bus.idata = 32'h00A0_0093;
    tick();
    chk_out("brtgt", 32'h104, 32'h00A0_0093, 32'h100, 1'b1, 2'd1);

    // 6. PC wrap
    bus.branch_PC_contral = 1'b1;
    bus.branch_PC = 32'hFFFF_FFFC;
    tick();
    chk_out("br2", 32'hFFFF_FFFC, 32'h13, 32'h0, 1'b0, 2'd0);
    bus.branch_PC_contral = 1'b0;
    bus.idata = 32'h0000_0011;
    tick();
    chk_out("wrap", 32'h0, 32'h11, 32'hFFFF_FFFC, 1'b1, 2'd1);

    // reset while full and in a wait state
    bus.stall_ID = 1'b1;
    bus.idata = 32'h0000_0022;
    tick();
    chk_out("refill", 32'h4, 32'h11, 32'hFFFF_FFFC, 1'b1, 2'd2);
    rst = 1'b0;
    bus.iready_n = 1'b1;
    tick();
    chk_out("rstfull", 32'h0, 32'h13, 32'h0, 1'b0, 2'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
